// File: rtl/memory_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_data_arbiter
// Description : Round-robin two-port arbiter for the unified memory data port,
//               sequencing each access through the memory's one-cycle read.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_data_arbiter #(
    parameter int DW         = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_write,
    input  logic [ADDR_WIDTH-1:0] p0_address,
    input  logic [DW-1:0]         p0_wdata,
    output logic                  p0_ack,
    output logic [DW-1:0]         p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_write,
    input  logic [ADDR_WIDTH-1:0] p1_address,
    input  logic [DW-1:0]         p1_wdata,
    output logic                  p1_ack,
    output logic [DW-1:0]         p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_data_address,
    output logic [DW-1:0]         mem_input_data,
    output logic                  mem_write_enable,
    input  logic [DW-1:0]         mem_output_data,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        READ_WAIT = 2'd2,
        ACK       = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_last_served;
    logic                    r_grant_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DW-1:0]           r_wdata;
    logic                    r_we;
    logic [DW-1:0]           r_p0_rdata;
    logic [DW-1:0]           r_p1_rdata;
    logic                    w_grant_valid;
    logic                    w_grant_port;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // On a tie the port that was not served last wins.
    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_grant_port  = 1'b0;
        p0_ack        = 1'b0;
        p1_ack        = 1'b0;
        busy          = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (p0_req && p1_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_port  = ~r_last_served;
                end else if (p0_req || p1_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_port  = p1_req;
                end
                if (w_grant_valid) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                w_next_state = r_we ? ACK : READ_WAIT;
            end
            READ_WAIT: begin
                w_next_state = ACK;
            end
            ACK: begin
                p0_ack       = ~r_grant_id;
                p1_ack       = r_grant_id;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_served <= 1'b1;
            r_grant_id    <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_p0_rdata    <= '0;
            r_p1_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_grant_id <= w_grant_port;
                        r_addr     <= w_grant_port ? p1_address : p0_address;
                        r_wdata    <= w_grant_port ? p1_wdata   : p0_wdata;
                        r_we       <= w_grant_port ? p1_write   : p0_write;
                    end
                end
                ACCESS: begin
                    r_we <= 1'b0;
                end
                READ_WAIT: begin
                    if (r_grant_id) begin
                        r_p1_rdata <= mem_output_data;
                    end else begin
                        r_p0_rdata <= mem_output_data;
                    end
                end
                ACK: begin
                    r_last_served <= r_grant_id;
                end
                default: begin
                    r_we <= 1'b0;
                end
            endcase
        end
    end

    assign mem_data_address = r_addr;
    assign mem_input_data   = r_wdata;
    assign mem_write_enable = r_we;
    assign grant_id         = r_grant_id;
    assign p0_rdata         = r_p0_rdata;
    assign p1_rdata         = r_p1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_memory_data_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_memory_data_arbiter
// Description : Directed and random checks of memory_data_arbiter against a
//               word-level memory scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_data_arbiter;

    localparam int DW         = 32;
    localparam int ADDR_WIDTH = 14;

    logic                  clock;
    logic                  reset;
    logic                  p0_req, p0_write, p0_ack;
    logic [ADDR_WIDTH-1:0] p0_address;
    logic [DW-1:0]         p0_wdata, p0_rdata;
    logic                  p1_req, p1_write, p1_ack;
    logic [ADDR_WIDTH-1:0] p1_address;
    logic [DW-1:0]         p1_wdata, p1_rdata;
    logic [ADDR_WIDTH-1:0] mem_data_address;
    logic [DW-1:0]         mem_input_data;
    logic                  mem_write_enable;
    logic [DW-1:0]         mem_output_data;
    logic                  busy;
    logic                  grant_id;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem_model [int];
    logic [DW-1:0] ref_mem   [int];
    logic [DW-1:0] exp_rd    [2];

    memory_data_arbiter #(.DW(DW), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .p0_req           (p0_req),
        .p0_write         (p0_write),
        .p0_address       (p0_address),
        .p0_wdata         (p0_wdata),
        .p0_ack           (p0_ack),
        .p0_rdata         (p0_rdata),
        .p1_req           (p1_req),
        .p1_write         (p1_write),
        .p1_address       (p1_address),
        .p1_wdata         (p1_wdata),
        .p1_ack           (p1_ack),
        .p1_rdata         (p1_rdata),
        .mem_data_address (mem_data_address),
        .mem_input_data   (mem_input_data),
        .mem_write_enable (mem_write_enable),
        .mem_output_data  (mem_output_data),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] preload(input logic [ADDR_WIDTH-1:0] a);
        return {16'hA5A5, 2'b00, a};
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [ADDR_WIDTH-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : preload(a);
    endfunction

    // Memory with a registered read port, preloaded with a known pattern
    always @(posedge clock) begin
        mem_output_data <= mem_model.exists(int'(mem_data_address)) ?
                           mem_model[int'(mem_data_address)] : preload(mem_data_address);
        if (mem_write_enable) mem_model[int'(mem_data_address)] = mem_input_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic rq, input logic wr,
                         input logic [ADDR_WIDTH-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            p0_req = rq; p0_write = wr; p0_address = a; p0_wdata = d;
        end else begin
            p1_req = rq; p1_write = wr; p1_address = a; p1_wdata = d;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(posedge clock); #1;
        check("rst_p0_ack",   32'(p0_ack), 0);
        check("rst_p1_ack",   32'(p1_ack), 0);
        check("rst_p0_rdata", p0_rdata, 0);
        check("rst_p1_rdata", p1_rdata, 0);
        check("rst_addr",     32'(mem_data_address), 0);
        check("rst_wdata",    mem_input_data, 0);
        check("rst_we",       32'(mem_write_enable), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_grant",    32'(grant_id), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // Waits (bounded) for any ack; reports which port, cycles taken, idle
    // cycles seen and the memory-side signals in the first cycle.
    task automatic wait_ack(output int port, output int lat, output int idle,
                            output logic we1, output logic we_late,
                            output logic [ADDR_WIDTH-1:0] a1, output logic [DW-1:0] d1);
        bit done;
        port = -1; lat = 0; idle = 0; we1 = 1'b0; we_late = 1'b0; a1 = '0; d1 = '0;
        done = 1'b0;
        for (int c = 1; c <= 12 && !done; c++) begin
            @(posedge clock); #1;
            if (!busy) idle++;
            if (c == 1) begin
                we1 = mem_write_enable; a1 = mem_data_address; d1 = mem_input_data;
            end else if (mem_write_enable) begin
                we_late = 1'b1;
            end
            if (p0_ack || p1_ack) begin
                lat  = c;
                port = (p0_ack && p1_ack) ? 2 : (p0_ack ? 0 : 1);
                done = 1'b1;
            end
        end
    endtask

    task automatic single_txn(input int p, input logic wr,
                              input logic [ADDR_WIDTH-1:0] a, input logic [DW-1:0] d);
        int port, lat, idle;
        logic we1, we_late;
        logic [ADDR_WIDTH-1:0] a1;
        logic [DW-1:0] d1;
        drive(p, 1'b1, wr, a, d);
        wait_ack(port, lat, idle, we1, we_late, a1, d1);
        check("txn_port",    port, p);
        check("txn_latency", lat, wr ? 2 : 3);
        check("txn_busy",    idle, 0);
        check("txn_we",      32'(we1), 32'(wr));
        check("txn_we_late", 32'(we_late), 0);
        check("txn_addr",    32'(a1), 32'(a));
        if (wr) begin
            check("txn_wdata", d1, d);
            ref_mem[int'(a)] = d;
        end else begin
            exp_rd[p] = ref_read(a);
        end
        check("txn_p0_rdata", p0_rdata, exp_rd[0]);
        check("txn_p1_rdata", p1_rdata, exp_rd[1]);
        drive(p, 1'b0, wr, a, d);
        @(posedge clock); #1;
        check("txn_idle_after", 32'(busy), 0);
    endtask

    initial begin
        int port, lat, idle, n0;
        logic we1, we_late, any_ack;
        logic [ADDR_WIDTH-1:0] a1;
        logic [DW-1:0] d1;
        logic [ADDR_WIDTH-1:0] lst [3];

        do_reset();

        // Simultaneous reads right after reset: grants alternate 0,1,0,1
        drive(0, 1'b1, 1'b0, 14'h0100, '0);
        drive(1, 1'b1, 1'b0, 14'h0200, '0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(port, lat, idle, we1, we_late, a1, d1);
            check("dual_port",    port, k % 2);
            check("dual_latency", lat, (k == 0) ? 3 : 4);
            check("dual_idle",    idle, (k == 0) ? 0 : 1);
            if (k % 2 == 0) begin
                exp_rd[0] = ref_read(14'h0100);
                check("dual_p0_rdata", p0_rdata, exp_rd[0]);
            end else begin
                exp_rd[1] = ref_read(14'h0200);
                check("dual_p1_rdata", p1_rdata, exp_rd[1]);
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(posedge clock); #1;

        // Port 0 write then read back
        single_txn(0, 1'b1, 14'h0010, 32'hDEADBEEF);
        single_txn(0, 1'b0, 14'h0010, '0);
        check("p0_readback", p0_rdata, 32'hDEADBEEF);

        // Top address via port 1, read by port 0
        single_txn(1, 1'b1, 14'h3FFF, 32'h00000005);
        single_txn(0, 1'b0, 14'h3FFF, '0);
        check("top_readback", p0_rdata, 32'h00000005);

        // Reset during the ACCESS cycle of a write
        drive(0, 1'b1, 1'b1, 14'h0020, 32'h12345678);
        @(posedge clock); #1;
        check("midrst_we_before", 32'(mem_write_enable), 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_we_after", 32'(mem_write_enable), 0);
        check("midrst_busy",     32'(busy), 0);
        drive(0, 1'b0, 1'b0, 14'h0020, '0);
        any_ack = 1'b0;
        repeat (2) begin @(posedge clock); #1; any_ack |= p0_ack | p1_ack; end
        reset = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        repeat (4) begin @(posedge clock); #1; any_ack |= p0_ack | p1_ack; end
        check("midrst_no_ack", 32'(any_ack), 0);
        single_txn(0, 1'b0, 14'h0020, '0);
        check("midrst_preload", p0_rdata, preload(14'h0020));

        // Port 1 held while port 0 issues three back-to-back reads
        do_reset();
        lst[0] = 14'h0010; lst[1] = 14'h0020; lst[2] = 14'h3FFF;
        n0 = 0;
        drive(1, 1'b1, 1'b0, 14'h0100, '0);
        drive(0, 1'b1, 1'b0, lst[0], '0);
        for (int k = 0; k < 5; k++) begin
            wait_ack(port, lat, idle, we1, we_late, a1, d1);
            check("held_port",    port, k % 2);
            check("held_latency", lat, (k == 0) ? 3 : 4);
            check("held_idle",    idle, (k == 0) ? 0 : 1);
            if (port == 0) begin
                exp_rd[0] = ref_read(lst[n0]);
                check("held_p0_rdata", p0_rdata, exp_rd[0]);
                n0++;
                if (n0 < 3) begin
                    drive(0, 1'b1, 1'b0, lst[n0], '0);
                end else begin
                    drive(0, 1'b0, 1'b0, '0, '0);
                    drive(1, 1'b0, 1'b0, '0, '0);
                end
            end else begin
                exp_rd[1] = ref_read(14'h0100);
                check("held_p1_rdata", p1_rdata, exp_rd[1]);
            end
        end
        @(posedge clock); #1;

        // Random single transactions against the scoreboard
        for (int i = 0; i < 24; i++) begin
            single_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15)),
                       32'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
